// File: rtl/imem_loader.sv
// Program-load and run-control stage in front of the Mips32 core: streams a program
// into instruction RAM, holds the core in reset, then supervises the run until halt or timeout.
module imem_loader #(
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = 8,
  parameter int RESET_HOLD = 4,
  parameter int MAX_CYCLES = 1990
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  input  logic [31:0]       raddr,
  output logic [31:0]       instr,
  output logic              cpu_reset,
  input  logic              cpu_halted,
  output logic              done,
  output logic              timeout,
  output logic [ADDR_W:0]   words_loaded,
  output logic [15:0]       run_cycles
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  localparam int                HOLD_W    = $clog2(RESET_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [15:0]       RUN_LAST  = 16'(MAX_CYCLES - 1);
  localparam logic [ADDR_W:0]   WORD_LAST = (ADDR_W + 1)'(DEPTH - 1);

  logic [31:0] mem [DEPTH];

  state_t            state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
  logic [ADDR_W:0]   words_next;
  logic [15:0]       cycles_next;
  logic              cpu_reset_next, done_next, timeout_next;
  logic              accept;

  // NOTE: every signal written here gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    hold_cnt_next  = hold_cnt;
    words_next     = words_loaded;
    cycles_next    = run_cycles;
    cpu_reset_next = cpu_reset;
    done_next      = done;
    timeout_next   = timeout;
    load_ready     = 1'b0;
    accept         = 1'b0;

    unique case (state)
      S_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          accept     = 1'b1;
          words_next = words_loaded + 1'b1;
          // The last RAM slot closes loading even without load_last.
          if (load_last || words_loaded == WORD_LAST) state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_next     = S_RUN;
          cpu_reset_next = 1'b0;
        end else begin
          hold_cnt_next = hold_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (cpu_halted) begin
          state_next     = S_DONE;
          done_next      = 1'b1;
          cpu_reset_next = 1'b1;
        end else if (run_cycles == RUN_LAST) begin
          state_next     = S_DONE;
          done_next      = 1'b1;
          timeout_next   = 1'b1;
          cpu_reset_next = 1'b1;
        end else begin
          cycles_next = run_cycles + 1'b1;
        end
      end
      S_DONE: ;
      default: state_next = S_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_LOAD;
      hold_cnt     <= '0;
      words_loaded <= '0;
      run_cycles   <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_next;
      hold_cnt     <= hold_cnt_next;
      words_loaded <= words_next;
      run_cycles   <= cycles_next;
      cpu_reset    <= cpu_reset_next;
      done         <= done_next;
      timeout      <= timeout_next;
    end
  end

  // NOTE: the RAM has no reset; stale contents are hidden by the words_loaded mask below.
  always_ff @(posedge clock) begin
    if (accept) mem[words_loaded[ADDR_W-1:0]] <= load_data;
  end

  // Full-width compare so out-of-range and upper-bit addresses read as NOP.
  always_comb begin
    instr = 32'h0;
    if (raddr < 32'(words_loaded)) instr = mem[raddr[ADDR_W-1:0]];
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected values and events,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              load_valid = 1'b0;
  logic              load_ready;
  logic [31:0]       load_data = '0;
  logic              load_last = 1'b0;
  logic [31:0]       raddr = '0;
  logic [31:0]       instr;
  logic              cpu_reset;
  logic              cpu_halted = 1'b0;
  logic              done;
  logic              timeout;
  logic [ADDR_W:0]   words_loaded;
  logic [15:0]       run_cycles;

  imem_loader #(.DEPTH(256), .ADDR_W(ADDR_W), .RESET_HOLD(4), .MAX_CYCLES(1990)) dut (
    .clock(clock), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .raddr(raddr), .instr(instr),
    .cpu_reset(cpu_reset), .cpu_halted(cpu_halted),
    .done(done), .timeout(timeout),
    .words_loaded(words_loaded), .run_cycles(run_cycles)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef enum {K_INSTR, K_WL, K_RC, K_DONE, K_TO, K_CPURST, K_READY} kind_t;
  typedef struct { kind_t kind; string name; logic [31:0] exp; } probe_t;
  typedef struct { int cyc; logic [31:0] rc; logic to; } done_t;

  probe_t probe_q[$];
  int     fall_q[$];
  done_t  done_q[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] prog [13] = '{32'd6494246, 32'd543358986, 32'd2164774, 32'd2367526, 32'd2170918,
                             32'd8525864, 32'd554172415, 32'd338886655, 32'd4194317,
                             32'd0, 32'd0, 32'd0, 32'd0};
  logic [31:0] w5 [5] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 32'h5555_0005};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sample(input kind_t k);
    case (k)
      K_INSTR:  return instr;
      K_WL:     return 32'(words_loaded);
      K_RC:     return 32'(run_cycles);
      K_DONE:   return 32'(done);
      K_TO:     return 32'(timeout);
      K_CPURST: return 32'(cpu_reset);
      default:  return 32'(load_ready);
    endcase
  endfunction

  // Monitor: drains pending probes and matches cpu_reset falls / done rises to expectations.
  logic prev_cpu_reset = 1'b1;
  logic prev_done = 1'b0;
  always @(negedge clock) begin
    probe_t p;
    done_t  d;
    while (probe_q.size() > 0) begin
      p = probe_q.pop_front();
      check(p.name, sample(p.kind), p.exp);
    end
    if (prev_cpu_reset && !cpu_reset) begin
      if (fall_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL cpu_reset_fall: unexpected fall at edge %0d", cyc);
      end else begin
        check("cpu_reset_fall_edge", cyc, fall_q.pop_front());
      end
    end
    if (!prev_done && done) begin
      if (done_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL done_rise: unexpected done at edge %0d", cyc);
      end else begin
        d = done_q.pop_front();
        check("done_edge", cyc, d.cyc);
        check("done_run_cycles", 32'(run_cycles), d.rc);
        check("done_timeout", 32'(timeout), 32'(d.to));
        check("done_cpu_reset", 32'(cpu_reset), 32'd1);
      end
    end
    prev_cpu_reset = cpu_reset;
    prev_done = done;
  end

  task automatic probe(input kind_t k, input string name, input logic [31:0] exp);
    probe_t p;
    p.kind = k; p.name = name; p.exp = exp;
    probe_q.push_back(p);
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  task automatic probe_instr(input logic [31:0] addr, input logic [31:0] exp, input string name);
    raddr = addr;
    probe(K_INSTR, name, exp);
    settle();
  endtask

  task automatic expect_done(input int at, input logic [31:0] rc, input logic to);
    done_t d;
    d.cyc = at; d.rc = rc; d.to = to;
    done_q.push_back(d);
  endtask

  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load_valid = 1'b0;
    load_last = 1'b0;
    cpu_halted = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    probe(K_CPURST, "rst_cpu_reset", 32'd1);
    probe(K_DONE, "rst_done", 32'd0);
    probe(K_TO, "rst_timeout", 32'd0);
    probe(K_WL, "rst_words_loaded", 32'd0);
    probe(K_RC, "rst_run_cycles", 32'd0);
    probe(K_READY, "rst_load_ready", 32'd1);
    probe_instr(32'd0, 32'd0, "rst_instr0");
  endtask

  // Streams the 13-word program back to back; returns the edge that accepted the last word.
  task automatic load_prog(output int last_edge);
    for (int i = 0; i < 13; i++) begin
      load_valid = 1'b1;
      load_data = prog[i];
      load_last = (i == 12);
      @(posedge clock);
      #1;
    end
    last_edge = cyc;
    load_valid = 1'b0;
    load_last = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, f;

    // 1: load, hold timing, fetch masking, halt at run_cycles 100
    do_reset();
    load_prog(e);
    f = e + 4;
    fall_q.push_back(f);
    probe(K_WL, "s1_words_loaded", 32'd13);
    probe(K_READY, "s1_ready_in_hold", 32'd0);
    probe(K_CPURST, "s1_cpu_reset_hold", 32'd1);
    probe_instr(32'd1, 32'd543358986, "s1_instr1");
    probe_instr(32'd13, 32'd0, "s1_instr13");
    probe_instr(32'd300, 32'd0, "s1_instr300");
    probe_instr(32'd0, 32'd6494246, "s1_instr0");
    probe_instr(32'h8000_0001, 32'd0, "s1_instr_upper_bits");
    wait_edge(f + 10);
    probe(K_RC, "s1_run_cycles_10", 32'd10);
    probe(K_CPURST, "s1_cpu_reset_run", 32'd0);
    settle();
    wait_edge(f + 100);
    cpu_halted = 1'b1;
    expect_done(f + 101, 32'd100, 1'b0);
    wait_edge(f + 104);
    cpu_halted = 1'b0;
    probe(K_RC, "s1_run_cycles_held", 32'd100);
    probe(K_TO, "s1_timeout", 32'd0);
    probe(K_DONE, "s1_done_sticky", 32'd1);
    probe(K_CPURST, "s1_cpu_reset_done", 32'd1);
    settle();

    // 2: no halt, cycle budget expires
    do_reset();
    load_prog(e);
    f = e + 4;
    fall_q.push_back(f);
    expect_done(f + 1990, 32'd1989, 1'b1);
    wait_edge(f + 1989);
    probe(K_RC, "s2_run_cycles_last", 32'd1989);
    probe(K_DONE, "s2_not_done_yet", 32'd0);
    settle();
    wait_edge(f + 1995);
    probe(K_RC, "s2_run_cycles_held", 32'd1989);
    probe(K_TO, "s2_timeout", 32'd1);
    probe(K_CPURST, "s2_cpu_reset", 32'd1);
    probe(K_WL, "s2_words_loaded", 32'd13);
    probe_instr(32'd2, 32'd2164774, "s2_instr2_after_done");

    // 3: 300 words without load_last, RAM fills at 256
    do_reset();
    for (int i = 0; i < 300; i++) begin
      load_valid = 1'b1;
      load_data = 32'hA500_0000 + 32'(i);
      load_last = 1'b0;
      @(posedge clock);
      #1;
      if (i == 254) probe(K_READY, "s3_ready_before_full", 32'd1);
      if (i == 255) begin
        fall_q.push_back(cyc + 4);
        probe(K_READY, "s3_ready_after_full", 32'd0);
      end
    end
    load_valid = 1'b0;
    probe(K_WL, "s3_words_loaded", 32'd256);
    probe_instr(32'd255, 32'hA500_00FF, "s3_instr255");
    probe_instr(32'd254, 32'hA500_00FE, "s3_instr254");
    probe_instr(32'd256, 32'd0, "s3_instr256");

    // 4: sparse valid during LOAD, halted held high early, words driven after LOAD
    do_reset();
    cpu_halted = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        load_valid = 1'b1;
        load_data = w5[i / 2];
        load_last = (i == 8);
      end else begin
        load_valid = 1'b0;
        load_data = 32'hDEAD_0000 + 32'(i);
        load_last = 1'b1;
      end
      @(posedge clock);
      #1;
      if (i == 8) e = cyc;
    end
    f = e + 4;
    fall_q.push_back(f);
    expect_done(f + 1, 32'd0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      load_valid = 1'b1;
      load_data = 32'hBAD0_0000 + 32'(k);
      load_last = 1'b1;
      @(posedge clock);
      #1;
    end
    load_valid = 1'b0;
    load_last = 1'b0;
    cpu_halted = 1'b0;
    probe(K_WL, "s4_words_loaded", 32'd5);
    probe(K_READY, "s4_ready", 32'd0);
    for (int j = 0; j < 5; j++) probe_instr(32'(j), w5[j], $sformatf("s4_instr%0d", j));
    probe_instr(32'd5, 32'd0, "s4_instr5");

    // 5: async reset mid-RUN, then reload reproduces scenario 1 timing
    do_reset();
    load_prog(e);
    f = e + 4;
    fall_q.push_back(f);
    wait_edge(f + 50);
    #1;
    raddr = 32'd1;
    reset = 1'b1;
    probe(K_CPURST, "s5_cpu_reset_async", 32'd1);
    probe(K_WL, "s5_words_loaded_async", 32'd0);
    probe(K_DONE, "s5_done_async", 32'd0);
    probe(K_RC, "s5_run_cycles_async", 32'd0);
    probe(K_INSTR, "s5_instr_masked", 32'd0);
    settle();
    @(posedge clock);
    #1;
    reset = 1'b0;
    load_prog(e);
    f = e + 4;
    fall_q.push_back(f);
    probe(K_WL, "s5_words_reloaded", 32'd13);
    probe_instr(32'd1, 32'd543358986, "s5_instr1_reloaded");
    wait_edge(f + 100);
    cpu_halted = 1'b1;
    expect_done(f + 101, 32'd100, 1'b0);
    wait_edge(f + 103);
    cpu_halted = 1'b0;
    probe(K_RC, "s5_run_cycles_held", 32'd100);
    settle();

    check("fall_queue_drained", 32'(fall_q.size()), 32'd0);
    check("done_queue_drained", 32'(done_q.size()), 32'd0);
    check("probe_queue_drained", 32'(probe_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
